rr_encode16_4: RTL and testbench

Registered 16-to-4 round-robin request encoder: the inverse of the processor's enabled 4-to-16 decoder. It captures one-cycle request pulses from up to 16 sources into a pending register and presents one source index at a time as a 4-bit code with a valid/ack handshake. It uses round-robin priority so no source starves. It sits in front of shared resources (register-file write port, exception/interrupt sources) that the 4-to-16 decoder then re-expands into one-hot selects.

---
 rtl/rr_encode16_4.sv | 87 ++++++++
 tb/tb_rr_encode16_4.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_encode16_4.sv
// rr_encode16_4: registered 16-to-4 round-robin request encoder.
// Captures request pulses into a pending register and grants one source
// index at a time with a valid/ack handshake. The search starts at the
// round-robin pointer, so no source starves.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   req     - request pulses/levels, bit i sets pending[i]
//   enable  - allows new grants to issue (capture always continues)
//   ack     - consumer accepts the current code while valid=1
//   out     - encoded index of the granted source (registered)
//   valid   - out holds a granted, un-acknowledged index (registered)
module rr_encode16_4 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] req,
   input  logic        enable,
   input  logic        ack,
   output logic [3:0]  out,
   output logic        valid
);

   localparam int unsigned NREQ = 16;
   localparam int unsigned CW   = 4;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state;
   logic [NREQ-1:0]   pending;
   logic [CW-1:0]     ptr;
   logic [CW-1:0]     sel_c;
   logic              found_c;
   logic [NREQ-1:0]   clr_c;

   // Rotating priority search: first set pending bit at ptr, ptr+1, ... (mod 16)
   always_comb begin
      sel_c   = '0;
      found_c = 1'b0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (!found_c && pending[ptr + CW'(i)]) begin
            sel_c   = ptr + CW'(i);
            found_c = 1'b1;
         end
      end
   end

   // One-hot clear of the acknowledged index
   always_comb begin
      clr_c = '0;
      if (state == GRANT && ack)
         clr_c[out] = 1'b1;
   end

   // Pending capture (set wins over clear) and grant FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
         ptr     <= '0;
         out     <= '0;
         valid   <= 1'b0;
         state   <= IDLE;
      end else begin
         pending <= (pending & ~clr_c) | req;
         case (state)
            IDLE: begin
               if (enable && found_c) begin
                  out   <= sel_c;
                  valid <= 1'b1;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (ack) begin
                  ptr   <= out + CW'(1);
                  valid <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               valid <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_encode16_4.sv
// Self-checking bench for rr_encode16_4: expected grant codes are queued
// when requests are driven and popped when the DUT raises valid.
module tb_rr_encode16_4;

   logic        clk;
   logic        reset_n;
   logic [15:0] req;
   logic        enable;
   logic        ack;
   logic [3:0]  out;
   logic        valid;

   int unsigned vectors;
   int unsigned miscompares;
   logic [3:0]  exp_q[$];

   rr_encode16_4 dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .enable  (enable),
      .ack     (ack),
      .out     (out),
      .valid   (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge, then settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-edge request pulse
   task automatic pulse(input logic [15:0] r);
      req = r;
      step();
      req = '0;
   endtask

   // Wait for valid, compare against the scoreboard, hold, then acknowledge
   task automatic serve(input int hold);
      logic [3:0] code;
      int n;
      n = 0;
      while (!valid && n < 20) begin
         step();
         n++;
      end
      if (!valid) begin
         chk("grant_timeout", 16'(valid), 16'd1);
         return;
      end
      if (exp_q.size() == 0) begin
         chk("sb_underflow", 16'(out), 16'hFFFF);
         return;
      end
      code = exp_q.pop_front();
      chk("grant_code", 16'(out), 16'(code));
      for (int h = 0; h < hold; h++) begin
         step();
         chk("hold_valid", 16'(valid), 16'd1);
         chk("hold_out", 16'(out), 16'(code));
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("ack_drop", 16'(valid), 16'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n = 1'b0;
      req     = '0;
      enable  = 1'b0;
      ack     = 1'b0;
      #1;
      chk("rst_valid", 16'(valid), 16'd0);
      chk("rst_out", 16'(out), 16'd0);
      step();
      step();
      #4 reset_n = 1'b1;
      enable = 1'b1;

      // Idle with nothing pending
      step();
      step();
      chk("idle_empty", 16'(valid), 16'd0);

      // Round-robin from ptr=0, ack one cycle after each valid, back-to-back spacing
      pulse(16'h8029);
      exp_q.push_back(4'd0); exp_q.push_back(4'd3);
      exp_q.push_back(4'd5); exp_q.push_back(4'd15);
      for (int k = 0; k < 4; k++) begin
         serve(1);
         if (k < 3) begin
            step();
            chk("rr_next_latency", 16'(valid), 16'd1);
         end
      end
      step();
      step();
      chk("rr_done_idle", 16'(valid), 16'd0);
      // ptr should be 0 again: 0 wins over 15
      pulse(16'h8001);
      exp_q.push_back(4'd0); exp_q.push_back(4'd15);
      serve(0);
      serve(0);

      // Single request with exact latency and hold
      req = 16'h0200;
      step();
      req = '0;
      chk("single_capture_no_grant", 16'(valid), 16'd0);
      step();
      chk("single_valid", 16'(valid), 16'd1);
      exp_q.push_back(4'd9);
      serve(3);
      step();
      step();
      chk("single_no_regrant", 16'(valid), 16'd0);

      // Wrap search from ptr=10: 12 then 2, leaving ptr=3
      pulse(16'h1004);
      exp_q.push_back(4'd12); exp_q.push_back(4'd2);
      serve(0);
      serve(0);
      // ptr=3: 4 before 2
      pulse(16'h0014);
      exp_q.push_back(4'd4); exp_q.push_back(4'd2);
      serve(0);
      serve(0);

      // Enable gating
      enable = 1'b0;
      pulse(16'h0010);
      for (int c = 0; c < 5; c++) begin
         chk("gate_blocked", 16'(valid), 16'd0);
         step();
      end
      enable = 1'b1;
      step();
      chk("gate_valid", 16'(valid), 16'd1);
      chk("gate_out", 16'(out), 16'd4);
      enable = 1'b0;
      step();
      step();
      chk("gate_held_valid", 16'(valid), 16'd1);
      chk("gate_held_out", 16'(out), 16'd4);
      exp_q.push_back(4'd4);
      serve(0);
      enable = 1'b1;

      // Set-wins collision on index 7
      pulse(16'h0080);
      exp_q.push_back(4'd7);
      step();
      chk("coll_valid", 16'(valid), 16'd1);
      chk("coll_out", 16'(out), 16'd7);
      ack = 1'b1;
      req = 16'h0080;
      step();
      ack = 1'b0;
      req = '0;
      chk("coll_ack_drop", 16'(valid), 16'd0);
      step();
      chk("coll_regrant_valid", 16'(valid), 16'd1);
      serve(0);

      // All 16 pending from ptr=8: strict rotation
      pulse(16'hFFFF);
      for (int k = 0; k < 16; k++) exp_q.push_back(4'(8 + k));
      for (int k = 0; k < 16; k++) serve(0);

      // Asynchronous reset mid-grant with out=6
      pulse(16'h0040);
      exp_q.push_back(4'd6);
      step();
      chk("pre_rst_out", 16'(out), 16'd6);
      chk("pre_rst_valid", 16'(valid), 16'd1);
      void'(exp_q.pop_front());
      req = 16'hFFFF;
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_valid", 16'(valid), 16'd0);
      chk("async_rst_out", 16'(out), 16'd0);
      step();
      step();
      req = '0;
      #3 reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("post_rst_idle", 16'(valid), 16'd0);
      end

      chk("sb_empty", 16'(exp_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
